// File: rtl/e_gpu_pkg.sv
// e_gpu_pkg: shared GPU types and defaults agreed between the controller and the compute units
package e_gpu_pkg;
   localparam int CU_NUM_WARPS       = 4;
   localparam int CU_MAX_OUTSTANDING = 16;
   localparam int CU_IDLE_CYCLES     = 8;
   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_WAIT_IDLE,
      S_SLEEP
   } cu_sleep_state_t;
endpackage

// File: rtl/cu_sleep_ctrl_if.sv
// cu_sleep_ctrl_if: compute-unit activity inputs and controller-facing sleep outputs
interface cu_sleep_ctrl_if #(
   parameter int NUM_WARPS       = 4,
   parameter int MAX_OUTSTANDING = 16
);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   logic                 cu_start_i;
   logic [NUM_WARPS-1:0] warp_active_i;
   logic                 mem_req_valid_i;
   logic                 mem_req_ready_i;
   logic                 mem_rsp_valid_i;
   logic                 sleep_req_o;
   logic                 delay_sleep_o;
   logic [CNT_W-1:0]     outstanding_o;
   logic                 err_o;
   modport slave (
      input  cu_start_i, warp_active_i, mem_req_valid_i, mem_req_ready_i, mem_rsp_valid_i,
      output sleep_req_o, delay_sleep_o, outstanding_o, err_o
   );
   modport master (
      output cu_start_i, warp_active_i, mem_req_valid_i, mem_req_ready_i, mem_rsp_valid_i,
      input  sleep_req_o, delay_sleep_o, outstanding_o, err_o
   );
endinterface

// File: rtl/req_tracker.sv
// req_tracker: saturating in-flight memory request counter with sticky overflow/underflow flag
module req_tracker #(
   parameter int MAX_OUTSTANDING = 16,
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o,
   output logic             err_o
);
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d, up, dn, ovf, unf;
   always_comb begin
      up      = inc_i && !dec_i;
      dn      = dec_i && !inc_i;
      ovf     = up && (count_q == CNT_W'(MAX_OUTSTANDING));
      unf     = dn && (count_q == '0);
      count_d = (up && !ovf) ? count_q + 1'b1 : (dn && !unf) ? count_q - 1'b1 : count_q;
      err_d   = err_q || ovf || unf;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end
   assign count_o = count_q;
   assign err_o   = err_q;
endmodule

// File: rtl/cu_sleep_ctrl.sv
// cu_sleep_ctrl: per-CU sleep sequencer requesting gating once warps retire, memory drains and an idle window passes
module cu_sleep_ctrl
   import e_gpu_pkg::*;
#(
   parameter int NUM_WARPS       = CU_NUM_WARPS,
   parameter int MAX_OUTSTANDING = CU_MAX_OUTSTANDING,
   parameter int IDLE_CYCLES     = CU_IDLE_CYCLES
) (
   input logic            clk_i,
   input logic            rst_ni,
   cu_sleep_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [NUM_WARPS-1:0] NO_WARPS = '0;
   cu_sleep_state_t  state_q, state_d;
   logic [7:0]       idle_q, idle_d;
   logic [CNT_W-1:0] outstanding;
   logic             hs, any_warp, activity;
   assign hs       = bus.mem_req_valid_i && bus.mem_req_ready_i;
   assign any_warp = bus.warp_active_i != NO_WARPS;
   assign activity = any_warp || bus.mem_req_valid_i || bus.cu_start_i;
   req_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_req_tracker (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (hs),
      .dec_i   (bus.mem_rsp_valid_i),
      .count_o (outstanding),
      .err_o   (bus.err_o)
   );
   // idle counter only advances in WAIT_IDLE; every other state leaves it cleared
   always_comb begin
      state_d = state_q;
      idle_d  = '0;
      case (state_q)
         S_IDLE:      state_d = bus.cu_start_i ? S_RUN : S_IDLE;
         S_RUN:       state_d = (!any_warp && !bus.cu_start_i) ? S_DRAIN : S_RUN;
         S_DRAIN:     state_d = any_warp ? S_RUN : (outstanding == '0 && !hs) ? S_WAIT_IDLE : S_DRAIN;
         S_WAIT_IDLE: begin
            state_d = activity ? S_RUN : (idle_q == 8'(IDLE_CYCLES - 1)) ? S_SLEEP : S_WAIT_IDLE;
            idle_d  = (activity || idle_q == 8'(IDLE_CYCLES - 1)) ? '0 : idle_q + 1'b1;
         end
         S_SLEEP:     state_d = bus.cu_start_i ? S_RUN : S_SLEEP;
         default:     state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         idle_q  <= '0;
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
      end
   end
   assign bus.sleep_req_o   = state_q == S_SLEEP;
   assign bus.delay_sleep_o = (state_q == S_DRAIN) || (state_q == S_WAIT_IDLE);
   assign bus.outstanding_o = outstanding;
endmodule

// File: doc/cu_sleep_ctrl.md
# cu_sleep_ctrl

Per-compute-unit sleep sequencer that sits directly upstream of the GPU controller. It generates the `cu_sleep_req` / `cu_delay_sleep` pair for one compute unit. It tracks warp activity and outstanding memory transactions, and asks the controller to gate and reset the unit only once all warps have retired, memory traffic has drained, and a programmable idle window has elapsed. One instance exists per compute unit, and its outputs feed the controller's per-CU sleep inputs.

## Interface
- `NUM_WARPS`, default 4: number of warp-active bits observed.
- `MAX_OUTSTANDING`, default 16: maximum in-flight memory requests tracked.
- `IDLE_CYCLES`, default 8: quiet cycles required before a sleep request; legal range 1..255.
- `clk_i`, in, 1: clock. Single clock domain.
- `rst_ni`, in, 1: reset, asynchronous and active-low.
- `cu_start_i`, in, 1: single-cycle kernel-launch pulse for this CU.
- `warp_active_i`, in, NUM_WARPS: per-warp active flags.
- `mem_req_valid_i`, in, 1: CU memory request valid.
- `mem_req_ready_i`, in, 1: CU memory request ready.
- `mem_rsp_valid_i`, in, 1: memory response returned. One pulse retires one request.
- `sleep_req_o`, out, 1: to the controller's `cu_sleep_req_i[n]`.
- `delay_sleep_o`, out, 1: to the controller's `cu_delay_sleep_i[n]`.
- `outstanding_o`, out, $clog2(MAX_OUTSTANDING+1): current in-flight count.
- `err_o`, out, 1: sticky flag for counter overflow or underflow. Cleared only by reset.

## Operation
- FSM states: IDLE, RUN, DRAIN, WAIT_IDLE, SLEEP. The reset state is IDLE.
- IDLE: moves to RUN on `cu_start_i`. All other inputs are ignored, except that the outstanding counter keeps updating.
- RUN: moves to DRAIN when `warp_active_i == 0` and `cu_start_i == 0`.
- DRAIN: moves to RUN if any warp becomes active again. Otherwise moves to WAIT_IDLE when outstanding is 0 and no request handshake occurs this cycle. Otherwise stays in DRAIN.
- WAIT_IDLE: "activity" means any `warp_active_i` bit set, `mem_req_valid_i`, or `cu_start_i`.
  - Activity moves the FSM to RUN and clears the idle counter.
  - Otherwise the idle counter increments. When the counter equals IDLE_CYCLES-1, the FSM moves to SLEEP.
- SLEEP: holds until reset. The controller is expected to gate the clock and pulse the CU reset.
  - Exception: `cu_start_i` in SLEEP moves the FSM to RUN. This covers the case where a start races the sleep.
- `sleep_req_o = (state == SLEEP)`.
- `delay_sleep_o = (state == DRAIN) || (state == WAIT_IDLE)`. It tells the controller a sleep is imminent but not yet safe.
- Outstanding counter updates:
  - +1 on a request handshake (`mem_req_valid_i && mem_req_ready_i`).
  - −1 on `mem_rsp_valid_i`.
  - Handshake and response in the same cycle: net 0.
- Counter boundaries:
  - Increment at MAX_OUTSTANDING: the count saturates and `err_o` is set.
  - Response at count 0: the count stays 0 and `err_o` is set.
- `warp_active_i` is sampled as-is. Synchronisation is upstream's responsibility.

## Timing
- All outputs are registered or decoded directly from registers. There is no combinational input-to-output path.
- Reset values: `sleep_req_o` = 0, `delay_sleep_o` = 0, `outstanding_o` = 0, `err_o` = 0, state = IDLE, idle counter = 0.
- `cu_start_i` at cycle t puts the FSM in RUN at t+1.
- Sleep latency: if WAIT_IDLE is entered at cycle t and no activity follows, `sleep_req_o` rises at t+IDLE_CYCLES.
- DRAIN to WAIT_IDLE: takes effect the cycle after the counter reads 0.
- Activity in the last idle cycle still aborts the sleep. `sleep_req_o` never pulses in that case.
- `outstanding_o` reflects a handshake or response one cycle after it occurs.
- Asserting reset mid-operation clears everything asynchronously. Release resumes in IDLE.

## Structure
- Shared package `e_gpu_pkg` holds:
  - The `cu_sleep_state_t` enum for the five states.
  - The `IDLE_CYCLES` default constant, so the controller and the CU agree on it.
- Parameter defaults follow the existing `e_gpu.vh` macros where they exist.
- One sub-module, `req_tracker`: the saturating up/down outstanding counter plus its error flag. It is parameterised by MAX_OUTSTANDING.
- The FSM and idle counter live in the top module.

## Test plan
- Basic sleep: reset, start pulse, warps 4'b0011 for 10 cycles, then 0, no memory traffic. `delay_sleep_o` goes high, and `sleep_req_o` rises exactly 8 cycles after entering WAIT_IDLE.
- Drain: leave 3 requests outstanding when the warps finish. The FSM stays in DRAIN with `delay_sleep_o` = 1. Three responses bring `outstanding_o` to 0, then WAIT_IDLE, then SLEEP after 8 more cycles.
- Abort: set `warp_active_i` = 4'b0100 at idle count 7. The FSM returns to RUN, `sleep_req_o` stays 0, and `delay_sleep_o` drops the next cycle.
- Simultaneous events: with count 5, a request handshake and response in the same cycle leave the count at 5. 17 handshakes with no response give count 16 and `err_o` = 1. A response at count 0 sets `err_o` and the count stays 0.
- Reset mid-operation: assert `rst_ni` = 0 in DRAIN with count 4. All outputs read 0 immediately, and the FSM is back in IDLE after release.
- Start racing sleep: `cu_start_i` in SLEEP returns the FSM to RUN next cycle, and `sleep_req_o` drops.
